// File: rtl/uart_tx.sv
// uart_tx: baud-rate-clocked UART transmitter, LSB-first framing with
// start bit, DATA_WIDTH data bits, optional even/odd parity and one stop bit.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept_c;
  logic                  par_bit_c;

  // A request is only taken when the line is idle or on its final stop bit.
  assign accept_c = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));

  // Parity derives from the latched frame, so input changes mid-frame are harmless.
  assign par_bit_c = par_typ_q ? ~(^data_q) : (^data_q);

  // State and datapath registers; reset abandons any frame and idles the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, bit counter, request latching and next line value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = START;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        state_d = accept_c ? START : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept_c) begin
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      cnt_d     = '0;
    end

    // Line value for the state being entered, so TX_OUT changes on the edge.
    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = data_q[cnt_d];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = par_bit_c;
        busy_d = 1'b1;
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the transmit end of the link whose receive end is UART_RX. It accepts a parallel byte with a one-cycle valid strobe and serialises it LSB-first on TX_OUT as start, data, optional parity and stop bits. It is clocked at the baud rate (one CLK period per bit), so no oversampling prescale is needed. Parity and framing match what UART_RX checks.

## Interface

- DATA_WIDTH, default 8: number of data bits per frame.

- CLK  input  1  bit-rate clock; one period per serial bit.
- RST  input  1  reset: one clock; reset is asynchronous and active-low.
- P_DATA  input  DATA_WIDTH  parallel data; sampled only on an accepting edge.
- DATA_VALID  input  1  request to send P_DATA; sampled on the rising edge of CLK.
- PAR_EN  input  1  1 = insert a parity bit after the data bits; sampled on an accepting edge.
- PAR_TYP  input  1  0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data); sampled on an accepting edge.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is on the line.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accepting edge: a rising edge of CLK where DATA_VALID=1 and the state is IDLE or STOP.
  - On that edge, P_DATA, PAR_EN and PAR_TYP are latched into internal registers.
  - The parity bit is computed from the latched data.
  - The state becomes START.
- In any other state, DATA_VALID is ignored; there is no queueing.
- Transitions:
  - IDLE -> START on an accepting edge.
  - START -> DATA.
  - DATA stays for DATA_WIDTH cycles. A bit counter of width $clog2(DATA_WIDTH) runs 0..DATA_WIDTH-1, and the state moves on at count DATA_WIDTH-1.
  - DATA -> PARITY if latched PAR_EN=1, else DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> START on an accepting edge (back-to-back frame), else STOP -> IDLE.
- TX_OUT is registered:
  - IDLE: 1.
  - START: 0.
  - DATA: latched data[counter], LSB first.
  - PARITY: latched parity bit.
  - STOP: 1.
- BUSY is registered: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- P_DATA, PAR_EN and PAR_TYP may change at any time after the accepting edge without affecting the frame in flight.
- Reset (RST=0, asynchronous):
  - State -> IDLE, counter -> 0, TX_OUT -> 1, BUSY -> 0, latched registers -> 0.
  - A frame in flight is abandoned immediately. The line returns high mid-bit, and the far end reports a framing error.

## Timing

- Reset values: TX_OUT=1, BUSY=0.
- Let E0 be the accepting edge. Immediately after E0: TX_OUT=0 (start bit) and BUSY=1. Latency from request to start bit is 1 edge.
- After E1..E_DATA_WIDTH: TX_OUT carries data bits 0..DATA_WIDTH-1.
- With PAR_EN=1 (DATA_WIDTH=8): parity is driven after E9, stop after E10, so the frame is 11 cycles.
- With PAR_EN=0: stop is driven after E9, so the frame is 10 cycles.
- The edge that ends the stop cycle:
  - DATA_VALID=1: TX_OUT goes to 0 (next start bit), BUSY stays 1, and there is zero idle gap between frames.
  - DATA_VALID=0: TX_OUT=1 and BUSY=0.
- Sustained throughput is one byte per 11 cycles (parity on) or 10 cycles (parity off).
- A DATA_VALID pulse that arrives while BUSY=1 (except during STOP) is lost. The upstream block must wait for BUSY=0, or present DATA_VALID during the stop cycle.
- Exactly one frame is sent per accepting edge. DATA_VALID held high produces continuous back-to-back frames, re-sampling P_DATA at each accepting edge.

## Test plan

- P_DATA=0xBB, PAR_EN=1, PAR_TYP=1, 1-cycle DATA_VALID -> TX_OUT after each edge: 0,1,1,0,1,1,1,0,1,1,1. BUSY is high for exactly 11 cycles, then TX_OUT=1 and BUSY=0.
- P_DATA=0x80, PAR_EN=1, PAR_TYP=0 -> TX_OUT: 0,0,0,0,0,0,0,0,1,1,1 (even parity bit = 1). Repeat with PAR_EN=0 and P_DATA=0xBB -> 0,1,1,0,1,1,1,0,1 then stop 1; BUSY is high for exactly 10 cycles.
- Back-to-back: DATA_VALID held high with P_DATA=0xA5, then 0x3C changed during the first frame's stop cycle, PAR_EN=0 -> two 10-bit frames with no idle bit between them. BUSY never drops. The second frame carries 0x3C.
- Mid-frame interference: DATA_VALID pulse with P_DATA=0xFF on cycle 4 of a 0x00 frame, plus PAR_TYP toggled mid-frame -> the original frame is sent unchanged, no second frame follows, and the parity follows the latched PAR_TYP.
- Reset mid-frame: assert RST after the 5th data bit -> TX_OUT=1 and BUSY=0 without waiting for a CLK edge. After release, a new 0xBB request produces a clean 11-cycle frame.
- Connect to UART_RX with matching PAR_EN and PAR_TYP, send 0x00, 0xFF and 0xBB -> the receiver reports data_valid with matching P_DATA and no parity or framing error.
